// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon game controller.
//   Fills a sequence RAM from a free-running LFSR when a game starts. Each
//   round it plays a longer prefix of the sequence as one-hot display_bits,
//   then checks the player's button presses against that prefix.
//
// Optional feature: define SIMON_TIMEOUT_EN to make the block lose after
//   TIMEOUT_CYCLES of player inactivity in WAIT_IN. Without the macro,
//   WAIT_IN waits forever and no timeout compare is built.
//
// Ports:
//   clk_50M      in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   level input; its rising edge starts a new game
//   btn[3:0]     in   raw active-high buttons, asynchronous to clk_50M
//   display_bits out  one-hot step being shown, 0 when dark
//   doneNormal   out  0 while the sequence is being shown, 1 otherwise
//   win          out  held high after a completed game
//   lose         out  held high after a wrong press (or timeout)
//   round[3:0]   out  current round, 1-based (reads 0 in round 16)
//   fsm_state    out  debug view of the FSM state:
//                     0 IDLE, 1 FILL, 2 SHOW_ON, 3 SHOW_GAP, 4 WAIT_IN,
//                     5 WIN, 6 LOSE
module simon_sequencer #(
  parameter int SEQ_LEN        = 8,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] display_bits,
  output logic       doneNormal,
  output logic       win,
  output logic       lose,
  output logic [3:0] round,
  output logic [2:0] fsm_state
);

  localparam int MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW      = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);
  localparam int IW      = ($clog2(SEQ_LEN) < 1) ? 1 : $clog2(SEQ_LEN);
  localparam int DEPTH   = 1 << IW;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [3:0]    LAST_IDX  = 4'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_GAP = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [3:0]    idx, idx_n, round_n, round_m1;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   lfsr;
  logic [1:0]    start_sync;
  logic          start_prev, start_edge;
  logic [3:0]    btn_s1, btn_s2, btn_prev, btn_edge;
  logic [1:0]    seq [DEPTH];
  logic [3:0]    expected;
  logic [1:0]    show_sel;
  logic [3:0]    display_n;
  logic          done_n, win_n, lose_n;

  assign fsm_state = state;

  // Input conditioning and LFSR. Edge pulses are registered so a press seen
  // on btn_edge in cycle N is acted on at the end of cycle N.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      start_sync <= '0;
      start_prev <= 1'b0;
      start_edge <= 1'b0;
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_prev   <= '0;
      btn_edge   <= '0;
      lfsr       <= 16'hACE1;
    end else begin
      start_sync <= {start_sync[0], start};
      start_prev <= start_sync[1];
      start_edge <= start_sync[1] & ~start_prev;
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
      btn_prev   <= btn_s2;
      btn_edge   <= btn_s2 & ~btn_prev;
      // Fibonacci form, taps 16,14,13,11, shifting towards bit 0.
      lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Sequence RAM, one entry per FILL cycle at address idx.
  always_ff @(posedge clk_50M) begin
    if (state == S_FILL) seq[idx[IW-1:0]] <= lfsr[1:0];
  end

  // round is stored 1-based in 4 bits, so round 16 wraps to 0; comparing
  // round-1 keeps the arithmetic correct for SEQ_LEN = 16.
  assign round_m1 = round - 4'd1;
  assign expected = 4'b0001 << seq[idx[IW-1:0]];

  // State register plus registered outputs.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      round        <= 4'd1;
      timer        <= '0;
      display_bits <= '0;
      doneNormal   <= 1'b1;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      round        <= round_n;
      timer        <= timer_n;
      display_bits <= display_n;
      doneNormal   <= done_n;
      win          <= win_n;
      lose         <= lose_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    round_n = round;
    timer_n = timer;
    unique case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_edge) begin
          state_n = S_FILL;
          idx_n   = '0;
        end
      end
      S_FILL: begin
        if (idx == LAST_IDX) begin
          state_n = S_SHOW_ON;
          idx_n   = '0;
          round_n = 4'd1;
          timer_n = '0;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      S_SHOW_ON: begin
        if (timer == SHOW_LAST) begin
          state_n = S_SHOW_GAP;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_SHOW_GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          if (idx < round_m1) begin
            idx_n   = idx + 4'd1;
            state_n = S_SHOW_ON;
          end else begin
            idx_n   = '0;
            state_n = S_WAIT_IN;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (btn_edge != 4'd0) begin
          // Several simultaneous edges never equal a one-hot value, so
          // they fall into the losing branch.
          if (btn_edge == expected) begin
            timer_n = '0;
            if (idx < round_m1) begin
              idx_n = idx + 4'd1;
            end else if (round_m1 == LAST_IDX) begin
              state_n = S_WIN;
            end else begin
              round_n = round + 4'd1;
              idx_n   = '0;
              state_n = S_SHOW_ON;
            end
          end else begin
            state_n = S_LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer == TO_LAST) begin
          state_n = S_LOSE;
        end else begin
          timer_n = timer + 1'b1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic, decoded from the next state so outputs change together
  // with the state. When FILL hands over with SEQ_LEN = 1, entry 0 is being
  // written this same cycle, so it is taken straight from the LFSR.
  always_comb begin
    if (state == S_FILL && idx_n == idx) show_sel = lfsr[1:0];
    else                                 show_sel = seq[idx_n[IW-1:0]];
    display_n = '0;
    done_n    = 1'b1;
    win_n     = 1'b0;
    lose_n    = 1'b0;
    unique case (state_n)
      S_SHOW_ON: begin
        display_n = 4'b0001 << show_sel;
        done_n    = 1'b0;
      end
      S_SHOW_GAP: done_n = 1'b0;
      S_WIN:      win_n  = 1'b1;
      S_LOSE:     lose_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed self-checking bench for simon_sequencer with
//   SEQ_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20. The colour
//   sequence is learned from display_bits in round 1 and later rounds must
//   replay the same prefix. Inputs are driven and outputs sampled on the
//   falling edge. Honours SIMON_TIMEOUT_EN for the idle-player checks.
module tb_simon_sequencer;

  localparam int SEQ_LEN        = 3;
  localparam int SHOW_CYCLES    = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_WIN  = 3'd5;
  localparam logic [2:0] ST_LOSE = 3'd6;

  logic       clk_50M = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] btn;
  logic [3:0] display_bits;
  logic       doneNormal, win, lose;
  logic [3:0] round;
  logic [2:0] fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [3:0] shown [3];
  logic [3:0] s0, s1, s2, wrong;

  simon_sequencer #(
    .SEQ_LEN(SEQ_LEN), .SHOW_CYCLES(SHOW_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_50M(clk_50M), .reset_n(reset_n), .start(start), .btn(btn),
    .display_bits(display_bits), .doneNormal(doneNormal), .win(win),
    .lose(lose), .round(round), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // Start edge to first lit step: 2 sync + 1 edge + SEQ_LEN fill + 1 cycles.
  task automatic start_game();
    int k;
    k = 0;
    start = 1'b1;
    do begin
      @(negedge clk_50M);
      k++;
      if (k == 2) start = 1'b0;
    end while (display_bits == 4'd0 && k < 100);
    start = 1'b0;
    check("start_latency", k, SEQ_LEN + 4);
    check("show_done_low", doneNormal, 1'b0);
    check("show_flags", {win, lose}, 2'b00);
  endtask

  // Watches round n being shown from its first lit cycle; records each step
  // in shown[]. With inject set, a wrong button, a start edge and then a
  // multi-button press arrive during SHOW_ON and SHOW_GAP.
  task automatic watch_round(input int n, input bit inject);
    int lit, dark;
    logic [3:0] v;
    check("show_round", round, n);
    for (int s = 0; s < n; s++) begin
      v = display_bits;
      check("step_onehot", $countones(v), 1);
      lit = 0;
      while (display_bits == v && lit < 50) begin
        if (inject) begin
          if (lit == 0) begin
            btn   = {v[2:0], v[3]};
            start = 1'b1;
          end else if (lit == 1) begin
            btn   = 4'd0;
            start = 1'b0;
          end else if (lit == 2) begin
            btn = ~v;
          end else if (lit == 3) begin
            btn = 4'd0;
          end
        end
        lit++;
        @(negedge clk_50M);
      end
      btn = 4'd0;
      start = 1'b0;
      check("lit_cycles", lit, SHOW_CYCLES);
      dark = 0;
      while (display_bits == 4'd0 && doneNormal == 1'b0 && dark < 50) begin
        dark++;
        @(negedge clk_50M);
      end
      check("gap_cycles", dark, GAP_CYCLES);
      shown[s] = v;
    end
    check("wait_done", doneNormal, 1'b1);
    check("wait_state", fsm_state, ST_WAIT);
  endtask

  // Leaves the bench three falling edges after the press: the edge pulse
  // has been registered but the FSM has not yet acted on it.
  task automatic press(input logic [3:0] b);
    btn = b;
    tick(2);
    btn = 4'd0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    btn     = 4'd0;
    tick(3);
    check("rst_display", display_bits, 4'd0);
    check("rst_done", doneNormal, 1'b1);
    check("rst_win", win, 1'b0);
    check("rst_lose", lose, 1'b0);
    check("rst_round", round, 4'd1);
    check("rst_state", fsm_state, ST_IDLE);
    reset_n = 1'b1;
    tick(3);

    // Full winning game.
    start_game();
    watch_round(1, 1'b0);
    s0 = shown[0];
    press(s0); tick(1);
    watch_round(2, 1'b0);
    check("r2_step0", shown[0], s0);
    s1 = shown[1];
    press(s0); tick(1);
    press(s1); tick(1);
    watch_round(3, 1'b0);
    check("r3_step0", shown[0], s0);
    check("r3_step1", shown[1], s1);
    s2 = shown[2];
    press(s0); tick(1);
    press(s1); tick(1);
    check("pre_win_state", fsm_state, ST_WAIT);
    press(s2);
    check("win_before_edge", win, 1'b0);
    tick(1);
    check("win_set", win, 1'b1);
    check("win_done", doneNormal, 1'b1);
    check("win_display", display_bits, 4'd0);
    check("win_state", fsm_state, ST_WIN);
    tick(10);
    check("win_held", win, 1'b1);
    start_game();
    check("win_cleared", win, 1'b0);

    // Wrong press on step 2 of round 2.
    watch_round(1, 1'b0);
    s0 = shown[0];
    press(s0); tick(1);
    watch_round(2, 1'b0);
    s1 = shown[1];
    press(s0); tick(1);
    check("mid_round_lose", lose, 1'b0);
    wrong = {s1[2:0], s1[3]};
    press(wrong);
    check("lose_before_edge", lose, 1'b0);
    tick(1);
    check("lose_set", lose, 1'b1);
    press(s1); tick(1);
    press(4'hF); tick(1);
    check("lose_held", lose, 1'b1);
    check("lose_done", doneNormal, 1'b1);
    check("lose_display", display_bits, 4'd0);
    check("lose_state", fsm_state, ST_LOSE);

    // Buttons and a start edge during the show are ignored.
    start_game();
    check("lose_cleared", lose, 1'b0);
    watch_round(1, 1'b1);
    check("ignored_round", round, 4'd1);
    check("ignored_lose", lose, 1'b0);

    // Idle player in WAIT_IN.
`ifdef SIMON_TIMEOUT_EN
    tick(TIMEOUT_CYCLES - 1);
    check("timeout_not_yet", lose, 1'b0);
    tick(1);
    check("timeout_lose", lose, 1'b1);
    start_game();
    watch_round(1, 1'b0);
`else
    tick(1000);
    check("idle_state", fsm_state, ST_WAIT);
    check("idle_lose", lose, 1'b0);
    check("idle_done", doneNormal, 1'b1);
`endif

    // Two buttons at once.
    press(4'b0011);
    check("multi_before_edge", lose, 1'b0);
    tick(1);
    check("multi_lose", lose, 1'b1);

    // Asynchronous reset in the middle of SHOW_ON.
    start_game();
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_display", display_bits, 4'd0);
    check("arst_done", doneNormal, 1'b1);
    check("arst_flags", {win, lose}, 2'b00);
    check("arst_round", round, 4'd1);
    check("arst_state", fsm_state, ST_IDLE);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
